pes_call_scheduler: RTL

- Upstream stage of pes_elevator: latches floor call buttons, selects the next target floor using a SCAN (sweep) policy, and drives the elevator's 8-bit one-hot request_floor.
- Consumes the elevator's complete and out_current_floor feedback.
- On arrival it holds a timed door dwell, then clears the served call.
- Floor encoding is one-hot, bit i = floor i, matching the elevator's shift-based floor register.

---
 rtl/pes_call_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pes_call_scheduler.sv
// pes_call_scheduler
//   Upstream scheduler for pes_elevator. It latches floor call buttons and
//   picks the next target floor with a SCAN (sweep) policy. It drives the
//   one-hot request_floor and, on arrival, holds a timed door dwell before
//   clearing the served call.
//
// Ports
//   clk               system clock, all logic on posedge
//   reset             synchronous, active-high reset
//   call_btn          call button vector, one bit per floor
//   complete          elevator has reached request_floor
//   out_current_floor elevator current floor, one-hot
//   hold              door/weight alert; freezes the dwell countdown
//   request_floor     registered one-hot target for the elevator
//   pending_calls     latched, unserved calls
//   sweep_up          current sweep direction (1 = up)
//   door_open         high while dwelling at a floor
//   busy              high in SERVE or DWELL
//   floor_fault       out_current_floor was zero or multi-hot
module pes_call_scheduler #(
    parameter int DWELL_CYCLES = 4,
    parameter int NUM_FLOORS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  complete,
    input  logic [NUM_FLOORS-1:0] out_current_floor,
    input  logic                  hold,
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic [NUM_FLOORS-1:0] pending_calls,
    output logic                  sweep_up,
    output logic                  door_open,
    output logic                  busy,
    output logic                  floor_fault
);

    localparam int         IDX_W        = $clog2(NUM_FLOORS);
    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] request_q, request_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic                  sweep_q, sweep_d;
    logic                  door_q, door_d;
    logic                  busy_q, busy_d;
    logic                  fault_q, fault_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [IDX_W-1:0]      cur_idx;
    logic                  fault_now;
    logic                  pend_here;
    logic                  press_here;
    logic                  at_request;

    logic                  up_found, dn_found;
    logic [IDX_W-1:0]      up_idx, dn_idx;
    logic                  tgt_found, tgt_up;
    logic [NUM_FLOORS-1:0] tgt_onehot;

    // Floor decode. cur_idx is only meaningful when fault_now is low.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (out_current_floor[i]) cur_idx = IDX_W'(i);
        end
        fault_now  = !$onehot(out_current_floor);
        pend_here  = |(pending_q & out_current_floor);
        press_here = |(call_btn & out_current_floor);
        at_request = (out_current_floor == request_q);
    end

    // SCAN target: nearest pending floor strictly above / below the car.
    // The current floor is excluded; a call there is served in place.
    always_comb begin
        up_found = 1'b0;
        up_idx   = '0;
        dn_found = 1'b0;
        dn_idx   = '0;
        // Descending scan so the last hit is the lowest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (i > int'(cur_idx))) begin
                up_found = 1'b1;
                up_idx   = IDX_W'(i);
            end
        end
        // Ascending scan so the last hit is the highest floor below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i] && (i < int'(cur_idx))) begin
                dn_found = 1'b1;
                dn_idx   = IDX_W'(i);
            end
        end
        tgt_found = up_found | dn_found;
        // Keep the sweep direction while it has work; otherwise reverse.
        tgt_up = sweep_q ? up_found : !dn_found;
        tgt_onehot = '0;
        if (tgt_up) tgt_onehot[up_idx] = 1'b1;
        else        tgt_onehot[dn_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        request_d  = request_q;
        sweep_d    = sweep_q;
        cnt_d      = cnt_q;
        clear_mask = '0;
        fault_d    = fault_now;

        // A bad floor reading freezes the controller; call capture continues.
        if (!fault_now) begin
            unique case (state_q)
                S_IDLE: begin
                    request_d = out_current_floor;
                    if (pend_here) begin
                        state_d    = S_DWELL;
                        clear_mask = out_current_floor;
                        cnt_d      = DWELL_RELOAD;
                    end else if (pending_q != '0) begin
                        state_d = S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (at_request && pend_here) begin
                        // Parked on the target: stop once the car reports done.
                        if (complete) begin
                            state_d    = S_DWELL;
                            clear_mask = out_current_floor;
                            cnt_d      = DWELL_RELOAD;
                        end
                    end else if (tgt_found) begin
                        request_d = tgt_onehot;
                        sweep_d   = tgt_up;
                    end else if (pend_here) begin
                        request_d = out_current_floor;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DWELL: begin
                    // Presses at the open floor are absorbed and restart the dwell.
                    clear_mask = out_current_floor;
                    if (press_here) begin
                        cnt_d = DWELL_RELOAD;
                    end else if (!hold) begin
                        if (cnt_q == 8'd0) begin
                            state_d = (pending_q != '0) ? S_SERVE : S_IDLE;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        pending_d = (pending_q | call_btn) & ~clear_mask;
        door_d    = (state_d == S_DWELL);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            request_q <= NUM_FLOORS'(1);
            pending_q <= '0;
            sweep_q   <= 1'b1;
            door_q    <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            request_q <= request_d;
            pending_q <= pending_d;
            sweep_q   <= sweep_d;
            door_q    <= door_d;
            busy_q    <= busy_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end
    end

    assign request_floor = request_q;
    assign pending_calls = pending_q;
    assign sweep_up      = sweep_q;
    assign door_open     = door_q;
    assign busy          = busy_q;
    assign floor_fault   = fault_q;

endmodule
